// File: rtl/key_event_decoder_if.sv
// ============================================================================
// Module      : key_event_decoder_if
// Description : Groups the debounced key event stream and the gesture pulse
//               outputs of the key event decoder into one bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_event_decoder_if;
    logic key_flag;
    logic key_value;
    logic short_press;
    logic double_click;
    logic long_press;
    logic repeat_press;
    logic key_busy;

    // Debouncer / stimulus side: drives the key events, observes gestures
    modport master (
        output key_flag,
        output key_value,
        input  short_press,
        input  double_click,
        input  long_press,
        input  repeat_press,
        input  key_busy
    );

    // Decoder side: consumes key events, produces gesture pulses
    modport slave (
        input  key_flag,
        input  key_value,
        output short_press,
        output double_click,
        output long_press,
        output repeat_press,
        output key_busy
    );
endinterface

`default_nettype wire

// File: rtl/key_event_decoder.sv
// ============================================================================
// Module      : key_event_decoder
// Description : Classifies a debounced key event stream (active-low key) into
//               one-cycle gesture pulses: short press, double click, long
//               press and auto-repeat while held.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event_decoder #(
    parameter int unsigned LONG_CNT   = 50_000_000,
    parameter int unsigned DCLICK_CNT = 15_000_000,
    parameter int unsigned REPEAT_CNT = 10_000_000,
    parameter int unsigned DCLICK_EN  = 1
) (
    input  wire                 sys_clk,
    input  wire                 sys_rst_n,
    key_event_decoder_if.slave  kev
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PRESS1    = 3'd1;
    localparam logic [2:0] S_LONG_HOLD = 3'd2;
    localparam logic [2:0] S_WAIT2     = 3'd3;
    localparam logic [2:0] S_PRESS2    = 3'd4;

    // Counter values sampled in the cycle each threshold is reached
    localparam logic [31:0] c_long_last   = LONG_CNT - 1;
    localparam logic [31:0] c_dclick_last = DCLICK_CNT - 1;
    localparam logic [31:0] c_repeat_last = REPEAT_CNT - 1;

    logic [2:0]  r_state;
    logic [31:0] r_cnt;
    logic        r_short;
    logic        r_double;
    logic        r_long;
    logic        r_repeat;
    logic        r_busy;

    logic        w_press_ev;
    logic        w_rel_ev;
    logic [2:0]  w_state_nxt;
    logic [31:0] w_cnt_nxt;
    logic        w_short;
    logic        w_double;
    logic        w_long;
    logic        w_repeat;

    // Key level only means something alongside its strobe
    assign w_press_ev = kev.key_flag & ~kev.key_value;
    assign w_rel_ev   = kev.key_flag &  kev.key_value;

    // Next-state, next-count and pulse decision for the sampled event
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 32'd1;
        w_short     = 1'b0;
        w_double    = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 32'd0;
                if (w_press_ev) begin
                    w_state_nxt = S_PRESS1;
                end
            end

            S_PRESS1: begin
                // Release outranks the long threshold in the same cycle
                if (w_rel_ev) begin
                    w_cnt_nxt = 32'd0;
                    if (DCLICK_EN != 0) begin
                        w_state_nxt = S_WAIT2;
                    end else begin
                        w_short     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_cnt == c_long_last) begin
                    w_long      = 1'b1;
                    w_cnt_nxt   = 32'd0;
                    w_state_nxt = S_LONG_HOLD;
                end
            end

            S_LONG_HOLD: begin
                // Release in the repeat threshold cycle suppresses the repeat
                if (w_rel_ev) begin
                    w_cnt_nxt   = 32'd0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_repeat_last) begin
                    w_repeat  = 1'b1;
                    w_cnt_nxt = 32'd0;
                end
            end

            S_WAIT2: begin
                // A second press in the timeout cycle still counts as a double
                if (w_press_ev) begin
                    w_cnt_nxt   = 32'd0;
                    w_state_nxt = S_PRESS2;
                end else if (r_cnt == c_dclick_last) begin
                    w_short     = 1'b1;
                    w_cnt_nxt   = 32'd0;
                    w_state_nxt = S_IDLE;
                end
            end

            S_PRESS2: begin
                // No long/repeat here; the count only saturates so it never wraps
                if (w_rel_ev) begin
                    w_double    = 1'b1;
                    w_cnt_nxt   = 32'd0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_long_last) begin
                    w_cnt_nxt = r_cnt;
                end
            end

            default: begin
                w_cnt_nxt   = 32'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counter and registered gesture outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 32'd0;
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_short  <= w_short;
            r_double <= w_double;
            r_long   <= w_long;
            r_repeat <= w_repeat;
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    assign kev.short_press  = r_short;
    assign kev.double_click = r_double;
    assign kev.long_press   = r_long;
    assign kev.repeat_press = r_repeat;
    assign kev.key_busy     = r_busy;

endmodule

`default_nettype wire
